// File: rtl/es_dsc_mul.sv
// es_dsc_mul: deterministic stochastic-computing multiplier.
// Each operand becomes a clock-division unary bitstream carved out of one
// shared counter. The streams are AND-ed, and the ones are counted over a
// full period, which gives the exact product.
// Optional feature: define ES_DSC_MUL_ZERO_SKIP_EN to finish immediately,
// with a zero result, when any operand is zero.
module es_dsc_mul #(
    parameter int DATA_WIDTH = 5,
    parameter int NUM_INPUTS = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH-1:0]            bin_data_in [NUM_INPUTS],
    output logic [DATA_WIDTH*NUM_INPUTS-1:0] bin_data_out,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             busy
);

    localparam int PW = DATA_WIDTH * NUM_INPUTS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [PW-1:0]         cnt;
    logic [PW-1:0]         acc;
    logic [PW-1:0]         acc_next;
    logic [DATA_WIDTH-1:0] x [NUM_INPUTS];
    logic                  accept;
    logic                  last;
    logic                  stream_bit;
    logic                  skip;

    assign in_ready  = (state == IDLE) && en;
    assign accept    = in_valid && in_ready;
    assign last      = &cnt;
    assign acc_next  = acc + {{(PW-1){1'b0}}, stream_bit};
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN);

`ifdef ES_DSC_MUL_ZERO_SKIP_EN
    logic any_zero;

    // Flag a zero operand at accept time so the run can be skipped entirely
    always_comb begin
        any_zero = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (bin_data_in[i] == '0) begin
                any_zero = 1'b1;
            end
        end
    end

    assign skip = any_zero;
`else
    assign skip = 1'b0;
`endif

    // Stream bit: operand i is 1 while its counter slice is below x[i]; all streams are AND-ed
    always_comb begin
        stream_bit = 1'b1;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (cnt[i*DATA_WIDTH +: DATA_WIDTH] >= x[i]) begin
                stream_bit = 1'b0;
            end
        end
    end

    // State register; reset discards any run or pending result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: accept -> RUN (or DONE on zero skip), full period -> DONE, consumer -> IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = skip ? DONE : RUN;
                end
            end
            RUN: begin
                if (en && last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (en && out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, step counter and accumulator in RUN, publish at period end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt          <= '0;
            acc          <= '0;
            bin_data_out <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                x[i] <= '0;
            end
        end else if (accept) begin
            x   <= bin_data_in;
            cnt <= '0;
            acc <= '0;
            if (skip) begin
                bin_data_out <= '0;
            end
        end else if ((state == RUN) && en) begin
            cnt <= cnt + PW'(1);
            acc <= acc_next;
            if (last) begin
                bin_data_out <= acc_next;
            end
        end
    end

endmodule

// File: tb/tb_es_dsc_mul.sv
// tb_es_dsc_mul: scoreboard bench for es_dsc_mul (N=2,W=5 and N=3,W=3).
// Honours ES_DSC_MUL_ZERO_SKIP_EN when choosing zero-operand expectations.
module tb_es_dsc_mul;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b1;
    logic       out_ready = 1'b1;
    logic       in_valid = 1'b0;
    logic [4:0] din [2];
    logic [9:0] dout;
    logic       in_ready;
    logic       out_valid;
    logic       busy;
    logic       in_valid3 = 1'b0;
    logic [2:0] din3 [3];
    logic [8:0] dout3;
    logic       in_ready3;
    logic       out_valid3;
    logic       busy3;

    int cyc = 0;
    int checks = 0;
    int passed = 0;

    typedef struct {
        int data;
        int acc_cyc;
        int lat;
    } exp_t;

    exp_t q2[$];
    exp_t q3[$];

`ifdef ES_DSC_MUL_ZERO_SKIP_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    es_dsc_mul #(.DATA_WIDTH(5), .NUM_INPUTS(2)) u_dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .bin_data_in(din), .bin_data_out(dout), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
    );

    es_dsc_mul #(.DATA_WIDTH(3), .NUM_INPUTS(3)) u_dut3 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid3), .in_ready(in_ready3),
        .bin_data_in(din3), .bin_data_out(dout3), .out_valid(out_valid3),
        .out_ready(out_ready), .busy(busy3)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle counter used to time accepts and results
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("[TB] FAIL %s: actual %0d required %0d", name, act, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    // Pops the expected entry when out_valid rises, then checks data stays held until handshake
    task automatic monitor(input bit sel);
        bit    prev = 1'b0;
        bit    stable = 1'b1;
        int    held = 0;
        int    ov;
        int    od;
        exp_t  e;
        string sfx;
        sfx = sel ? "_w3" : "";
        forever begin
            @(negedge clk);
            ov = sel ? int'(out_valid3) : int'(out_valid);
            od = sel ? int'(dout3) : int'(dout);
            if (!rst) begin
                prev = 1'b0;
            end else begin
                if (ov != 0 && !prev) begin
                    if ((sel ? q3.size() : q2.size()) == 0) begin
                        check_output({"spurious_out", sfx}, 1, 0);
                    end else begin
                        if (sel) e = q3.pop_front();
                        else e = q2.pop_front();
                        check_output({"product", sfx}, od, e.data);
                        check_output({"latency", sfx}, cyc - e.acc_cyc, e.lat);
                        held = od;
                        stable = 1'b1;
                    end
                end else if (ov != 0 && od != held) begin
                    stable = 1'b0;
                end
                if (ov != 0 && out_ready && en) check_output({"held_stable", sfx}, int'(stable), 1);
                prev = (ov != 0);
            end
        end
    endtask

    task automatic wait_ready(input bit sel, output int acc);
        int n = 0;
        while (!(sel ? in_ready3 : in_ready) && n < 3000) begin
            step();
            n++;
        end
        if (n >= 3000) check_output("accept_timeout", 0, 1);
        acc = cyc;
    endtask

    task automatic wait_result(input bit sel, output int bc);
        int n = 0;
        bc = 0;
        forever begin
            if (sel ? out_valid3 : out_valid) break;
            if (n >= 3000) begin
                check_output("result_timeout", 0, 1);
                break;
            end
            bc += int'(sel ? busy3 : busy);
            step();
            n++;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((out_valid || out_valid3) && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic apply_stimulus(input int a, input int b, input int lat);
        int   acc;
        exp_t e;
        din[0] = a[4:0];
        din[1] = b[4:0];
        in_valid = 1'b1;
        wait_ready(1'b0, acc);
        e.data = a * b;
        e.acc_cyc = acc;
        e.lat = lat;
        q2.push_back(e);
        step();
        in_valid = 1'b0;
    endtask

    // Directed sequence; the monitors run alongside and do the result checking
    initial begin
        int   bc;
        int   acc;
        int   hs;
        bit   ov_ok;
        bit   ir_ok;
        exp_t e;
        din[0] = '0;
        din[1] = '0;
        for (int i = 0; i < 3; i++) din3[i] = '0;
        fork
            monitor(1'b0);
            monitor(1'b1);
        join_none

        step();
        step();
        check_output("rst_in_ready", int'(in_ready), 1);
        check_output("rst_out_valid", int'(out_valid), 0);
        check_output("rst_busy", int'(busy), 0);
        check_output("rst_data", int'(dout), 0);
        rst = 1'b1;
        step();

        apply_stimulus(3, 7, 1025);
        wait_result(1'b0, bc);
        check_output("busy_cycles", bc, 1024);
        drain();

        apply_stimulus(31, 31, 1025);
        wait_result(1'b0, bc);
        drain();

        for (int i = 0; i < 3; i++) din3[i] = 3'd7;
        in_valid3 = 1'b1;
        wait_ready(1'b1, acc);
        e.data = 343;
        e.acc_cyc = acc;
        e.lat = 513;
        q3.push_back(e);
        step();
        in_valid3 = 1'b0;
        wait_result(1'b1, bc);
        check_output("busy_cycles_w3", bc, 512);
        drain();

        out_ready = 1'b0;
        apply_stimulus(5, 6, 1025);
        wait_result(1'b0, bc);
        ov_ok = 1'b1;
        ir_ok = 1'b1;
        repeat (20) begin
            step();
            if (!out_valid) ov_ok = 1'b0;
            if (in_ready) ir_ok = 1'b0;
        end
        check_output("bp_out_valid_held", int'(ov_ok), 1);
        check_output("bp_in_ready_low", int'(ir_ok), 1);
        out_ready = 1'b1;
        drain();

        apply_stimulus(5, 6, 1035);
        repeat (99) step();
        en = 1'b0;
        repeat (10) step();
        en = 1'b1;
        wait_result(1'b0, bc);
        drain();

        apply_stimulus(9, 9, 1025);
        repeat (299) step();
        rst = 1'b0;
        #1;
        check_output("midrun_rst_out_valid", int'(out_valid), 0);
        check_output("midrun_rst_busy", int'(busy), 0);
        check_output("midrun_rst_in_ready", int'(in_ready), 1);
        check_output("midrun_rst_data", int'(dout), 0);
        q2.delete();
        step();
        rst = 1'b1;
        step();

        apply_stimulus(2, 4, 1025);
        wait_result(1'b0, bc);
        drain();

        apply_stimulus(0, 17, ZS ? 1 : 1025);
        wait_result(1'b0, bc);
        check_output("zero_busy_cycles", bc, ZS ? 0 : 1024);
        drain();

        din[0] = 5'd4;
        din[1] = 5'd5;
        in_valid = 1'b1;
        wait_ready(1'b0, acc);
        e.data = 20;
        e.acc_cyc = acc;
        e.lat = 1025;
        q2.push_back(e);
        step();
        din[0] = 5'd6;
        din[1] = 5'd7;
        hs = -10;
        for (int n = 0; n < 3000; n++) begin
            if (out_valid && out_ready) hs = cyc;
            if (in_ready) break;
            step();
        end
        acc = cyc;
        check_output("next_accept_after_handshake", acc, hs + 1);
        e.data = 42;
        e.acc_cyc = acc;
        e.lat = 1025;
        q2.push_back(e);
        step();
        in_valid = 1'b0;
        wait_result(1'b0, bc);
        drain();

        repeat (3) step();
        check_output("scoreboard_drained", q2.size() + q3.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/es_dsc_mul.md
# es_dsc_mul

Parametrised deterministic stochastic-computing multiplier. It multiplies NUM_INPUTS unsigned DATA_WIDTH-bit operands by generating clock-division unary bitstreams, AND-ing them and counting ones over one full period, which yields the exact product. It adds a valid/ready handshake on both sides, a stall enable and an optional zero-operand early exit. It is the drop-in arithmetic engine for the arch-sweep `core` wrappers.

## Interface
- DATA_WIDTH, 5: operand width W; legal range 1..12.
- NUM_INPUTS, 2: operand count N; legal range 2..4; N*W ≤ 24.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- en  in  1  global enable; when 0 the block holds all state.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands; = (state==IDLE) && en.
- bin_data_in  in  [W-1:0] x [N]  unpacked operand array, captured on accept.
- bin_data_out  out  N*W  product; held stable while out_valid=1.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- busy  out  1  high in RUN.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: accept when in_valid && in_ready. Latch the operands into x[i], clear the N*W-bit sequence counter cnt and the N*W-bit accumulator acc, then go to RUN.
- RUN, each cycle with en=1:
  - Slice s_i = cnt[i*W +: W]. Slice 0 is fastest; each slice increments when all lower slices wrap, which gives clock division.
  - Stream bit b = AND over i of (s_i < x[i]).
  - Update acc += b and cnt += 1.
  - When the cycle processed cnt == all-ones, go to DONE.
- Period P = 2^(N*W) cycles. Final acc equals the product of all x[i] exactly.
- The maximum product (2^W−1)^N < 2^(N*W), so acc cannot overflow and there is no saturation logic.
- DONE: out_valid=1 and bin_data_out=acc. When out_ready && en, clear out_valid and go to IDLE.
- With en=0 in any state, cnt, acc, state and the outputs hold. in_ready is 0 while en=0.
- Reset, including mid-RUN or in DONE: go to IDLE immediately. cnt, acc, x[] and bin_data_out are cleared, and any pending result is discarded.

## Timing
- Reset values: in_ready=en (state is IDLE), out_valid=0, busy=0, bin_data_out=0.
- Accept at edge T0. busy=1 from T0+1 through T0+P. out_valid=1 from T0+P+1, which gives latency P+1 cycles with en held at 1.
- Each cycle with en=0 during RUN adds exactly one cycle of latency.
- DONE with out_ready=1 at edge Td: out_valid=0 and in_ready=1 from Td+1. The earliest next accept is Td+1, so there is no same-cycle result-out/operand-in overlap.
- in_valid while not in_ready is ignored, and the operands are not sampled.
- bin_data_out changes only on the RUN→DONE edge and on reset. It holds its last value in IDLE.
- out_ready in IDLE or RUN has no effect.

## Configuration
- ES_DSC_MUL_ZERO_SKIP_EN defined:
  - On accept, if any operand is 0, the block goes directly to DONE with acc=0.
  - out_valid is asserted at T0+1 and busy never rises.
- Macro undefined: a zero operand runs the full P-cycle period and returns 0 at T0+P+1.

## Test plan
- N=2, W=5: operands {3,7}, out_ready=1. Expect bin_data_out=21 with out_valid rising exactly 1025 cycles after accept, and busy high for 1024 cycles.
- N=2, W=5: operands {31,31} → 961. N=3, W=3: operands {7,7,7} → 343 after 513 cycles. Expect no overflow.
- Backpressure and stall:
  - {5,6} with out_ready=0 for 20 cycles: 30 is held stable, out_valid stays 1 and in_ready stays 0.
  - Deassert en for 10 cycles mid-RUN: the result is still 30, and latency grows by exactly 10.
- Reset mid-RUN: accept {9,9}, pull rst low at cycle 300. Expect out_valid=0, busy=0, in_ready=1 and bin_data_out=0 asynchronously. A subsequent accept of {2,4} gives 8 with full latency.
- Zero operand {0,17}:
  - ES_DSC_MUL_ZERO_SKIP_EN defined: expect 0 at T0+1 with busy=0.
  - Macro undefined: expect 0 at T0+1025.
- Handshake corner: in_valid held high across DONE→IDLE. Expect the second operand set to be accepted on the cycle after out_ready, not the same cycle, and both results to be correct in order.
